// File: rtl/mem_pkg.sv
// Request encodings, state and owner types shared by the scratchpad port arbiter.
package mem_pkg;

   localparam logic M_XRD = 1'b0;
   localparam logic M_XWR = 1'b1;

   localparam logic [2:0] MT_B = 3'd0;
   localparam logic [2:0] MT_H = 3'd1;
   localparam logic [2:0] MT_W = 3'd3;

   localparam int MEM_AW = 32;
   localparam int MEM_DW = 32;

   typedef struct packed {
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] data;
      logic              fcn;
      logic [2:0]        typ;
   } mem_req_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HTIF = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// whichever port was not granted last.
module rr_arb2
   import mem_pkg::*;
(
   input  logic   c_valid,
   input  logic   h_valid,
   input  owner_e rr_last,
   output logic   c_grant,
   output logic   h_grant
);

   always_comb begin
      c_grant = c_valid && (!h_valid || (rr_last == OWN_HTIF));
      h_grant = h_valid && (!c_valid || (rr_last == OWN_CORE));
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one scratchpad port between the core and HTIF data ports, keeping
// exactly one request outstanding and routing each response to its owner.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req_valid,
   output logic          c_req_ready,
   input  logic [AW-1:0] c_req_addr,
   input  logic [DW-1:0] c_req_data,
   input  logic          c_req_fcn,
   input  logic [2:0]    c_req_typ,
   output logic          c_resp_valid,
   output logic [DW-1:0] c_resp_data,
   input  logic          h_req_valid,
   output logic          h_req_ready,
   input  logic [AW-1:0] h_req_addr,
   input  logic [DW-1:0] h_req_data,
   input  logic          h_req_fcn,
   input  logic [2:0]    h_req_typ,
   output logic          h_resp_valid,
   output logic [DW-1:0] h_resp_data,
   output logic          m_req_valid,
   input  logic          m_req_ready,
   output logic [AW-1:0] m_req_addr,
   output logic [DW-1:0] m_req_data,
   output logic          m_req_fcn,
   output logic [2:0]    m_req_typ,
   input  logic          m_resp_valid,
   input  logic [DW-1:0] m_resp_data,
   output logic          err_spurious
);

   arb_state_e state_reg, state_next;
   owner_e     owner_reg, owner_next;
   owner_e     rr_last_reg, rr_last_next;
   mem_req_t   buf_reg, buf_next;
   logic       err_reg, err_next;
   logic       c_grant, h_grant;

   rr_arb2 u_rr_arb2 (
      .c_valid (c_req_valid),
      .h_valid (h_req_valid),
      .rr_last (rr_last_reg),
      .c_grant (c_grant),
      .h_grant (h_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         owner_reg   <= OWN_CORE;
         rr_last_reg <= OWN_HTIF;
         buf_reg     <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         rr_last_reg <= rr_last_next;
         buf_reg     <= buf_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      owner_next   = owner_reg;
      rr_last_next = rr_last_reg;
      buf_next     = buf_reg;
      err_next     = err_reg;
      c_req_ready  = 1'b0;
      h_req_ready  = 1'b0;
      m_req_valid  = 1'b0;
      m_req_addr   = '0;
      m_req_data   = '0;
      m_req_fcn    = 1'b0;
      m_req_typ    = '0;
      c_resp_valid = 1'b0;
      h_resp_valid = 1'b0;

      case (state_reg)
         S_IDLE: begin
            c_req_ready = c_grant;
            h_req_ready = h_grant;
            if (c_grant || h_grant) begin
               owner_next    = c_grant ? OWN_CORE : OWN_HTIF;
               rr_last_next  = c_grant ? OWN_CORE : OWN_HTIF;
               buf_next.addr = c_grant ? MEM_AW'(c_req_addr) : MEM_AW'(h_req_addr);
               buf_next.data = c_grant ? MEM_DW'(c_req_data) : MEM_DW'(h_req_data);
               buf_next.fcn  = c_grant ? c_req_fcn : h_req_fcn;
               buf_next.typ  = c_grant ? c_req_typ : h_req_typ;
               state_next    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            m_req_valid = 1'b1;
            m_req_addr  = AW'(buf_reg.addr);
            m_req_data  = DW'(buf_reg.data);
            m_req_fcn   = buf_reg.fcn;
            m_req_typ   = buf_reg.typ;
            if (m_req_ready) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (m_resp_valid) begin
               c_resp_valid = (owner_reg == OWN_CORE);
               h_resp_valid = (owner_reg == OWN_HTIF);
               state_next   = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // A response with nothing outstanding is dropped but remembered until reset.
      if (m_resp_valid && (state_reg != S_WAIT)) begin
         err_next = 1'b1;
      end
   end

   assign c_resp_data  = m_resp_data;
   assign h_resp_data  = m_resp_data;
   assign err_spurious = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level
// reference model, a behavioural memory and a response monitor.
module tb_mem_port_arbiter;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req_valid, c_req_ready, c_req_fcn, c_resp_valid;
   logic [31:0] c_req_addr, c_req_data, c_resp_data;
   logic [2:0]  c_req_typ;
   logic        h_req_valid, h_req_ready, h_req_fcn, h_resp_valid;
   logic [31:0] h_req_addr, h_req_data, h_resp_data;
   logic [2:0]  h_req_typ;
   logic        m_req_valid, m_req_ready, m_req_fcn, m_resp_valid;
   logic [31:0] m_req_addr, m_req_data, m_resp_data;
   logic [2:0]  m_req_typ;
   logic        err_spurious;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_addr(c_req_addr),
      .c_req_data(c_req_data), .c_req_fcn(c_req_fcn), .c_req_typ(c_req_typ),
      .c_resp_valid(c_resp_valid), .c_resp_data(c_resp_data),
      .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_addr(h_req_addr),
      .h_req_data(h_req_data), .h_req_fcn(h_req_fcn), .h_req_typ(h_req_typ),
      .h_resp_valid(h_resp_valid), .h_resp_data(h_resp_data),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
      .m_req_data(m_req_data), .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ),
      .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
      .err_spurious(err_spurious)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        fcn;
      logic [2:0]  typ;
      int          owner;   // 0 = core, 1 = HTIF
      int          epoch;
   } req_s;

   typedef struct {
      int          owner;
      logic [31:0] data;
   } resp_s;

   int checks = 0;
   int failures = 0;

   // Reference model state, written only by the monitor.
   req_s  req_q[$];
   req_s  inflight[$];
   int    busy, last_owner, waiting, err_exp, epoch, resp_rd;
   bit    c_fire, h_fire, end_done;
   // Expected responses, pushed only by the memory when it answers.
   resp_s exp_resp[$];
   logic [31:0] mem_arr [logic [31:0]];
   // Memory behaviour knobs, written only by the stimulus process.
   int    mem_ready_mode;  // 0 random, 1 stall, 2 always ready
   int    mem_delay;       // <0 random 0..3 extra cycles
   bit    mem_hold, inject_req, end_req;

   function automatic logic [31:0] default_word(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural scratchpad: accepts forwarded requests, answers each once.
   initial begin : memory
      int   rd_idx;
      int   cnt;
      bit   have;
      req_s cur;
      rd_idx = 0; cnt = 0; have = 1'b0;
      m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
      forever begin
         @(posedge clk); #2;
         m_resp_valid = 1'b0;
         m_resp_data  = $urandom;
         if (!have && rd_idx < inflight.size()) begin
            cur  = inflight[rd_idx];
            rd_idx++;
            have = 1'b1;
            cnt  = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
         end
         if (inject_req) begin
            m_resp_valid = 1'b1;
         end else if (have && !mem_hold) begin
            if (cnt == 0) begin
               if (cur.fcn == M_XWR) mem_arr[cur.addr] = cur.data;
               else m_resp_data = mem_arr.exists(cur.addr) ? mem_arr[cur.addr] : default_word(cur.addr);
               m_resp_valid = 1'b1;
               have = 1'b0;
               if (cur.epoch == epoch) exp_resp.push_back('{owner: cur.owner, data: m_resp_data});
            end else begin
               cnt--;
            end
         end
         case (mem_ready_mode)
            0:       m_req_ready = 1'($urandom_range(0, 1));
            1:       m_req_ready = 1'b0;
            default: m_req_ready = 1'b1;
         endcase
      end
   end

   // Reference model and response monitor, sampled mid-cycle.
   initial begin : monitor
      logic  exp_c, exp_h;
      req_s  n;
      resp_s r;
      busy = 0; last_owner = 1; waiting = 0; err_exp = 0; epoch = 0; resp_rd = 0;
      c_fire = 1'b0; h_fire = 1'b0; end_done = 1'b0;
      forever begin
         @(negedge clk);
         c_fire = c_req_valid && c_req_ready;
         h_fire = h_req_valid && h_req_ready;
         if (rst) begin
            busy = 0; last_owner = 1; waiting = 0; err_exp = 0;
            req_q.delete();
            epoch++;
            c_fire = 1'b0; h_fire = 1'b0;
            resp_rd = exp_resp.size();
         end else begin
            exp_c = 1'b0; exp_h = 1'b0;
            if (busy == 0) begin
               if (c_req_valid && h_req_valid) begin
                  exp_c = (last_owner == 1);
                  exp_h = (last_owner == 0);
               end else begin
                  exp_c = c_req_valid;
                  exp_h = h_req_valid;
               end
            end
            chk("c_req_ready", 32'(c_req_ready), 32'(exp_c));
            chk("h_req_ready", 32'(h_req_ready), 32'(exp_h));

            chk("m_req_valid", 32'(m_req_valid), 32'(req_q.size() != 0));
            if (req_q.size() != 0) begin
               chk("m_req_addr", m_req_addr, req_q[0].addr);
               chk("m_req_data", m_req_data, req_q[0].data);
               chk("m_req_fcn",  32'(m_req_fcn), 32'(req_q[0].fcn));
               chk("m_req_typ",  32'(m_req_typ), 32'(req_q[0].typ));
               if (m_req_ready) begin
                  inflight.push_back(req_q.pop_front());
                  waiting = 1;
               end
            end else begin
               chk("m_req_idle_zero", m_req_addr | m_req_data | 32'(m_req_fcn) | 32'(m_req_typ), 32'h0);
            end

            if (exp_c || exp_h) begin
               n.owner = exp_h ? 1 : 0;
               n.addr  = exp_h ? h_req_addr : c_req_addr;
               n.data  = exp_h ? h_req_data : c_req_data;
               n.fcn   = exp_h ? h_req_fcn  : c_req_fcn;
               n.typ   = exp_h ? h_req_typ  : c_req_typ;
               n.epoch = epoch;
               req_q.push_back(n);
               busy = 1;
               last_owner = n.owner;
            end

            chk("err_spurious", 32'(err_spurious), 32'(err_exp));
            chk("resp_onehot", 32'(c_resp_valid & h_resp_valid), 32'h0);
            if (c_resp_valid || h_resp_valid) begin
               chk("resp_expected", 32'(resp_rd < exp_resp.size()), 32'h1);
               if (resp_rd < exp_resp.size()) begin
                  r = exp_resp[resp_rd];
                  resp_rd++;
                  chk("resp_owner", 32'(h_resp_valid), 32'(r.owner));
                  chk("resp_data", c_resp_valid ? c_resp_data : h_resp_data, r.data);
               end
            end
            chk("resp_missing", 32'(resp_rd), 32'(exp_resp.size()));
            resp_rd = exp_resp.size();

            if (m_resp_valid) begin
               if (waiting != 0) begin
                  waiting = 0;
                  busy = 0;
               end else begin
                  err_exp = 1;
               end
            end
         end
         if (end_req && !end_done) begin
            chk("req_q_drained", 32'(req_q.size()), 32'h0);
            chk("inflight_busy", 32'(busy), 32'h0);
            end_done = 1'b1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   function automatic logic [2:0] rand_typ();
      int unsigned t;
      t = $urandom_range(0, 2);
      return (t == 2) ? MT_W : 3'(t);
   endfunction

   task automatic one_req(input bit is_h, input logic [31:0] a, input logic [31:0] d,
                          input logic f, input logic [2:0] t);
      if (is_h) begin
         h_req_valid = 1'b1; h_req_addr = a; h_req_data = d; h_req_fcn = f; h_req_typ = t;
      end else begin
         c_req_valid = 1'b1; c_req_addr = a; c_req_data = d; c_req_fcn = f; c_req_typ = t;
      end
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (is_h ? h_fire : c_fire) break;
      end
      c_req_valid = 1'b0;
      h_req_valid = 1'b0;
   endtask

   task automatic rand_step(input bit both);
      if (!c_req_valid || c_fire) begin
         c_req_valid = both || ($urandom_range(0, 2) != 0);
         c_req_addr  = 32'($urandom_range(0, 15)) << 2;
         c_req_data  = $urandom;
         c_req_fcn   = 1'($urandom_range(0, 1));
         c_req_typ   = rand_typ();
      end else if (!both && $urandom_range(0, 9) == 0) begin
         c_req_valid = 1'b0;
      end
      if (!h_req_valid || h_fire) begin
         h_req_valid = both || ($urandom_range(0, 2) != 0);
         h_req_addr  = 32'($urandom_range(0, 15)) << 2;
         h_req_data  = $urandom;
         h_req_fcn   = 1'($urandom_range(0, 1));
         h_req_typ   = rand_typ();
      end else if (!both && $urandom_range(0, 9) == 0) begin
         h_req_valid = 1'b0;
      end
      cyc();
   endtask

   initial begin : stim
      rst = 1'b1;
      c_req_valid = 1'b0; c_req_addr = '0; c_req_data = '0; c_req_fcn = 1'b0; c_req_typ = '0;
      h_req_valid = 1'b0; h_req_addr = '0; h_req_data = '0; h_req_fcn = 1'b0; h_req_typ = '0;
      mem_ready_mode = 2; mem_delay = 1; mem_hold = 1'b0; inject_req = 1'b0; end_req = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (2) cyc();

      one_req(1'b0, 32'h40, 32'h0, M_XRD, MT_W);
      repeat (8) cyc();
      one_req(1'b1, 32'h10, 32'hAB, M_XWR, MT_B);
      repeat (8) cyc();

      mem_delay = -1; mem_ready_mode = 0;
      repeat (80) rand_step(1'b1);

      for (int k = 0; k < 4; k++) begin
         mem_ready_mode = 1;
         repeat (6) rand_step(1'b1);
         mem_ready_mode = 0;
         repeat (10) rand_step(1'b1);
      end

      repeat (1500) rand_step(1'b0);

      c_req_valid = 1'b0; h_req_valid = 1'b0;
      repeat (30) cyc();

      inject_req = 1'b1;
      cyc();
      inject_req = 1'b0;
      repeat (5) cyc();

      mem_hold = 1'b1; mem_ready_mode = 2;
      one_req(1'b0, 32'h80, 32'h0, M_XRD, MT_W);
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (2) cyc();
      mem_hold = 1'b0;
      repeat (8) cyc();

      end_req = 1'b1;
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
